// File: rtl/j2c_pkg.sv
// -----------------------------------------------------------------------------
// j2c_pkg
// Shared definitions for the J2C transmit scheduler: the byte width of the
// master's data input, the default number of clocks each byte is held, and the
// scheduler state encoding.
// -----------------------------------------------------------------------------
package j2c_pkg;

    // Byte width presented to the J2C master data input.
    localparam int MESSAGE_LENGTH      = 8;

    // Default clocks per byte (20 x 40 ns = 800 ns at a 25 MHz clock).
    localparam int BYTE_CYCLES_DEFAULT = 20;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/j2c_rr_arbiter.sv
// -----------------------------------------------------------------------------
// j2c_rr_arbiter
// Round-robin requester selection. The grant is combinational: the lowest
// requesting index strictly above the pointer wins; if none is above it, the
// lowest requesting index overall wins. The pointer is a register updated only
// when pointer_load_i is asserted, and resets to NUM_REQ-1 so index 0 has
// priority first.
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-high reset
//   req_i            request vector, one bit per requester
//   pointer_load_i   load pointer_value_i into the pointer this clock
//   pointer_value_i  new pointer value (the requester just served)
//   grant_valid_o    at least one requester is asking
//   grant_idx_o      selected requester index
// -----------------------------------------------------------------------------
module j2c_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       pointer_load_i,
    input  logic [$clog2(NUM_REQ)-1:0] pointer_value_i,
    output logic                       grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] above_mask_s;
    logic [NUM_REQ-1:0] masked_req_s;

    // Index of the lowest set bit of vec (0 when vec is empty).
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_REQ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    // Masked-priority grant: prefer requesters above the pointer, then wrap.
    always_comb begin
        above_mask_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above_mask_s[i] = (IDX_W'(i) > ptr_q);
        end
        masked_req_s  = req_i & above_mask_s;
        grant_valid_o = |req_i;
        if (|masked_req_s) begin
            grant_idx_o = first_set(masked_req_s);
        end else begin
            grant_idx_o = first_set(req_i);
        end
    end

    // Pointer next-state: only moves when the scheduler finishes a frame.
    always_comb begin
        if (pointer_load_i) begin
            ptr_d = pointer_value_i;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/j2c_tx_scheduler.sv
// -----------------------------------------------------------------------------
// j2c_tx_scheduler
// Shares one J2C serial master between NUM_REQ byte-stream requesters. A
// frame is granted round-robin, the master's reset is released while the frame
// is sent, and every byte is held on m_data for exactly BYTE_CYCLES clocks. A
// mid-frame underrun longer than MAX_STALL clocks aborts the frame.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  per-requester byte available
//   req_data   per-requester byte, requester i in slice i
//   req_last   per-requester last-byte-of-frame flag
//   req_ready  combinational accept (only the granted bit can be high)
//   m_data     byte to master data input (registered)
//   m_reset    master reset (registered, high between frames)
//   grant_id   current or most recently granted requester
//   busy       a frame is in progress
//   abort      one-clock pulse when a frame is abandoned on underrun
// -----------------------------------------------------------------------------
module j2c_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int MESSAGE_LENGTH = j2c_pkg::MESSAGE_LENGTH,
    parameter int BYTE_CYCLES    = j2c_pkg::BYTE_CYCLES_DEFAULT,
    parameter int MAX_STALL      = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [MESSAGE_LENGTH-1:0]         m_data,
    output logic                              m_reset,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              abort
);

    import j2c_pkg::*;

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(BYTE_CYCLES);
    localparam int STALL_W = $clog2(MAX_STALL + 1);

    localparam logic [CNT_W-1:0]   CNT_RELOAD  = CNT_W'(BYTE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_FINAL = STALL_W'(MAX_STALL - 1);

    state_e                    state_q,   state_d;
    logic [IDX_W-1:0]          grant_q,   grant_d;
    logic [MESSAGE_LENGTH-1:0] m_data_q,  m_data_d;
    logic                      m_reset_q, m_reset_d;
    logic                      busy_q,    busy_d;
    logic                      abort_q,   abort_d;
    logic                      last_q,    last_d;
    logic [CNT_W-1:0]          cnt_q,     cnt_d;
    logic [STALL_W-1:0]        stall_q,   stall_d;

    logic [MESSAGE_LENGTH-1:0] req_bytes_s [NUM_REQ];
    logic                      sel_valid_s;
    logic                      sel_last_s;
    logic [MESSAGE_LENGTH-1:0] sel_data_s;
    logic [NUM_REQ-1:0]        ready_s;
    logic                      ptr_load_s;
    logic                      arb_valid_s;
    logic [IDX_W-1:0]          arb_grant_s;

    j2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk             (clk),
        .reset           (reset),
        .req_i           (req_valid),
        .pointer_load_i  (ptr_load_s),
        .pointer_value_i (grant_q),
        .grant_valid_o   (arb_valid_s),
        .grant_idx_o     (arb_grant_s)
    );

    // Unpack the flat data bus and pick out the granted requester's signals.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes_s[i] = req_data[i*MESSAGE_LENGTH +: MESSAGE_LENGTH];
        end
        sel_valid_s = req_valid[grant_q];
        sel_last_s  = req_last[grant_q];
        sel_data_s  = req_bytes_s[grant_q];
    end

    // Next-state and handshake logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        m_data_d   = m_data_q;
        m_reset_d  = m_reset_q;
        busy_d     = busy_q;
        abort_d    = 1'b0;
        last_d     = last_q;
        cnt_d      = cnt_q;
        stall_d    = stall_q;
        ready_s    = '0;
        ptr_load_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                m_reset_d = 1'b1;
                if (arb_valid_s) begin
                    grant_d = arb_grant_s;
                    busy_d  = 1'b1;
                    stall_d = '0;
                    state_d = ST_FETCH;
                end else begin
                    busy_d  = 1'b0;
                end
            end

            ST_FETCH: begin
                ready_s[grant_q] = sel_valid_s;
                if (sel_valid_s) begin
                    m_data_d  = sel_data_s;
                    last_d    = sel_last_s;
                    m_reset_d = 1'b0;
                    cnt_d     = CNT_RELOAD;
                    state_d   = ST_HOLD;
                end else if (stall_q == STALL_FINAL) begin
                    // Underrun budget exhausted: drop the frame, m_data keeps its value.
                    abort_d   = 1'b1;
                    m_reset_d = 1'b1;
                    busy_d    = 1'b0;
                    stall_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    stall_d   = stall_q + STALL_W'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (last_q) begin
                    m_reset_d  = 1'b1;
                    busy_d     = 1'b0;
                    ptr_load_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    // Final window clock: accepting here keeps bytes back-to-back.
                    ready_s[grant_q] = sel_valid_s;
                    if (sel_valid_s) begin
                        m_data_d = sel_data_s;
                        last_d   = sel_last_s;
                        cnt_d    = CNT_RELOAD;
                    end else begin
                        stall_d  = '0;
                        state_d  = ST_FETCH;
                    end
                end
            end

            default: begin
                m_reset_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            m_data_q  <= '0;
            m_reset_q <= 1'b1;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            m_data_q  <= m_data_d;
            m_reset_q <= m_reset_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign req_ready = ready_s;
    assign m_data    = m_data_q;
    assign m_reset   = m_reset_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_j2c_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_j2c_tx_scheduler
// Scoreboard bench. A per-cycle reference model, written in terms of absolute
// cycle numbers (byte accepted at c -> window ends at c+BYTE_CYCLES, next byte
// may be taken in [c+BYTE_CYCLES, c+BYTE_CYCLES+MAX_STALL]), pushes the expected
// outputs for every clock into a queue; a monitor pops and compares on the
// falling edge. Requesters are driven from per-requester byte queues.
// -----------------------------------------------------------------------------
module tb_j2c_tx_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BC = 20;
    localparam int MS = 20;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   m_data;
    logic           m_reset;
    logic [1:0]     grant_id;
    logic           busy;
    logic           abort;

    j2c_tx_scheduler #(
        .NUM_REQ        (N),
        .MESSAGE_LENGTH (W),
        .BYTE_CYCLES    (BC),
        .MAX_STALL      (MS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .m_data    (m_data),
        .m_reset   (m_reset),
        .grant_id  (grant_id),
        .busy      (busy),
        .abort     (abort)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        bit           last;
        int           gap;
    } item_t;

    typedef struct {
        logic [N-1:0] ready;
        logic [W-1:0] data;
        logic         mreset;
        logic [1:0]   grant;
        logic         busy;
        logic         abort;
    } exp_t;

    item_t rq [N][$];
    bit    pend [N];
    int    gapc [N];
    exp_t  exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int           cyc = 0;
    bit           mdl_busy, mdl_ending, mdl_mreset, mdl_abort, mdl_xfer;
    int           mdl_owner, mdl_ptr, mdl_next_from, mdl_deadline, mdl_end_cyc;
    logic [W-1:0] mdl_data;
    logic [N-1:0] mdl_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    endtask

    task automatic push_byte(input int r, input logic [W-1:0] d, input bit last, input int gap);
        item_t it;
        if (rq[r].size() == 0 && !pend[r]) gapc[r] = 0;
        it.data = d;
        it.last = last;
        it.gap  = gap;
        rq[r].push_back(it);
    endtask

    // Round-robin: requester closest after the last-served pointer, cyclically.
    function automatic int rr_pick();
        int best  = 0;
        int bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            int d = (i - mdl_ptr - 1 + 2 * N) % N;
            if (req_valid[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        mdl_busy   = 1'b0;
        mdl_ending = 1'b0;
        mdl_mreset = 1'b1;
        mdl_abort  = 1'b0;
        mdl_xfer   = 1'b0;
        mdl_owner  = 0;
        mdl_ptr    = N - 1;
        mdl_data   = '0;
        mdl_ready  = '0;
    endtask

    // Requester side: raise valid once the front byte's gap has elapsed.
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && rq[i].size() > 0) begin
                if (gapc[i] >= rq[i][0].gap) pend[i] = 1'b1;
                else gapc[i]++;
            end
            req_valid[i] = pend[i];
            if (rq[i].size() > 0) begin
                req_data[i*W +: W] = rq[i][0].data;
                req_last[i]        = rq[i][0].last;
            end else begin
                req_data[i*W +: W] = '0;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // Expected accept for the current cycle.
    task automatic model_comb();
        mdl_ready = '0;
        mdl_xfer  = 1'b0;
        if (mdl_busy && !mdl_ending && cyc >= mdl_next_from && cyc <= mdl_deadline) begin
            mdl_ready[mdl_owner] = req_valid[mdl_owner];
            mdl_xfer             = req_valid[mdl_owner];
        end
    endtask

    // Effect of the clock edge closing cycle cyc.
    task automatic model_edge();
        item_t b;
        mdl_abort = 1'b0;
        if (!mdl_busy) begin
            if (req_valid != '0) begin
                mdl_owner     = rr_pick();
                mdl_busy      = 1'b1;
                mdl_ending    = 1'b0;
                mdl_next_from = cyc + 1;
                mdl_deadline  = cyc + MS;
            end
        end else if (mdl_xfer) begin
            b = rq[mdl_owner].pop_front();
            pend[mdl_owner] = 1'b0;
            gapc[mdl_owner] = 0;
            mdl_data   = b.data;
            mdl_mreset = 1'b0;
            if (b.last) begin
                mdl_ending  = 1'b1;
                mdl_end_cyc = cyc + BC;
            end else begin
                mdl_next_from = cyc + BC;
                mdl_deadline  = cyc + BC + MS;
            end
        end else if (mdl_ending) begin
            if (cyc == mdl_end_cyc) begin
                mdl_mreset = 1'b1;
                mdl_busy   = 1'b0;
                mdl_ptr    = mdl_owner;
            end
        end else if (cyc == mdl_deadline) begin
            mdl_abort  = 1'b1;
            mdl_mreset = 1'b1;
            mdl_busy   = 1'b0;
        end
        cyc++;
    endtask

    task automatic push_exp();
        exp_t e;
        e.ready  = mdl_ready;
        e.data   = mdl_data;
        e.mreset = mdl_mreset;
        e.grant  = 2'(mdl_owner);
        e.busy   = mdl_busy;
        e.abort  = mdl_abort;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        drive_inputs();
        model_comb();
        push_exp();
    endtask

    // Called at posedge+1: asserts reset mid-cycle so its effect is asynchronous.
    task automatic apply_reset();
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        push_exp();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_inputs();
        model_comb();
        push_exp();
    endtask

    task automatic run_until_idle(input int max_cycles);
        bit done = 1'b0;
        for (int k = 0; k < max_cycles && !done; k++) begin
            step();
            done = !mdl_busy;
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) done = 1'b0;
            end
        end
        check("drain_in_budget", 32'(done), 32'd1);
        repeat (3) step();
    endtask

    // Monitor: compare every registered output and the accept vector.
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("req_ready",     32'(req_ready),          32'(mon_e.ready));
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            check("m_data",        32'(m_data),             32'(mon_e.data));
            check("m_reset",       32'(m_reset),            32'(mon_e.mreset));
            check("grant_id",      32'(grant_id),           32'(mon_e.grant));
            check("busy",          32'(busy),               32'(mon_e.busy));
            check("abort",         32'(abort),              32'(mon_e.abort));
        end
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            gapc[i] = 0;
        end
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // single frame from requester 0
        push_byte(0, 8'h5F, 1'b0, 0);
        push_byte(0, 8'h95, 1'b0, 0);
        push_byte(0, 8'hF0, 1'b0, 0);
        push_byte(0, 8'h0F, 1'b1, 0);
        run_until_idle(400);

        // round robin: req0 then req2, then req0's second frame
        push_byte(0, 8'h11, 1'b0, 0);
        push_byte(0, 8'h12, 1'b1, 0);
        push_byte(2, 8'h21, 1'b0, 0);
        push_byte(2, 8'h22, 1'b1, 0);
        push_byte(0, 8'h13, 1'b0, 0);
        push_byte(0, 8'h14, 1'b1, 0);
        run_until_idle(600);

        // underrun: a non-last byte with nothing following
        push_byte(1, 8'hAA, 1'b0, 0);
        run_until_idle(400);

        // late second byte, five clocks after its window closes
        push_byte(3, 8'h31, 1'b0, 0);
        push_byte(3, 8'h32, 1'b1, BC + 4);
        run_until_idle(400);

        // reset during the second byte of req0's frame
        push_byte(0, 8'h41, 1'b0, 0);
        push_byte(0, 8'h42, 1'b0, 0);
        push_byte(0, 8'h43, 1'b1, 0);
        push_byte(2, 8'h51, 1'b1, 0);
        repeat (30) step();
        apply_reset();
        run_until_idle(600);

        // all requesters at once
        for (int r = 0; r < N; r++) begin
            push_byte(r, 8'(8'h60 + r), 1'b0, 0);
            push_byte(r, 8'(8'h70 + r), 1'b1, 0);
        end
        run_until_idle(1000);

        // randomized frames, gaps and underruns
        for (int round = 0; round < 3; round++) begin
            for (int r = 0; r < N; r++) begin
                int nf = $urandom_range(1, 3);
                for (int f = 0; f < nf; f++) begin
                    int nb = $urandom_range(1, 4);
                    for (int b = 0; b < nb; b++) begin
                        int gap;
                        if ($urandom_range(0, 9) == 0) gap = BC + MS + $urandom_range(1, 10);
                        else gap = $urandom_range(0, BC + 5);
                        push_byte(r, 8'($urandom), (b == nb - 1), gap);
                    end
                end
            end
            run_until_idle(20000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
